// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor:
// 2-bit direction counter encodings and their saturating update.
package bp_pkg;

    localparam int unsigned STAT_W = 32;
    localparam int unsigned CTR_W  = 2;

    typedef enum logic [CTR_W-1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // New entries start weakly taken so one not-taken outcome flips them.
    localparam ctr_e CTR_ALLOC = CTR_WT;

    function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
        ctr_e res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr_e'(CTR_W'(ctr) + CTR_W'(1));
        end else begin
            if (ctr != CTR_SNT) res = ctr_e'(CTR_W'(ctr) - CTR_W'(1));
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX training and statistics signals of the branch predictor.
interface branch_predictor_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_BITS = 12
);

    logic [PC_BITS-1:0] F_pc;
    logic               F_BP_taken;
    logic [PC_BITS-1:0] F_BP_target_pc;
    logic               EX_brn;
    logic [PC_BITS-1:0] EX_pc;
    logic               EX_true_taken;
    logic [XLEN-1:0]    EX_alu_out;
    logic               EX_taken;
    logic [31:0]        BP_branch_cnt;
    logic [31:0]        BP_mispred_cnt;

    modport master (
        output F_pc, EX_brn, EX_pc, EX_true_taken, EX_alu_out, EX_taken,
        input  F_BP_taken, F_BP_target_pc, BP_branch_cnt, BP_mispred_cnt
    );

    modport slave (
        input  F_pc, EX_brn, EX_pc, EX_true_taken, EX_alu_out, EX_taken,
        output F_BP_taken, F_BP_target_pc, BP_branch_cnt, BP_mispred_cnt
    );

endinterface

// File: rtl/bp_stat_ctr.sv
// 32-bit event counter that saturates at all-ones instead of wrapping.
module bp_stat_ctr
    import bp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_q;
    logic [STAT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {STAT_W{1'b1}})) count_d = count_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters; combinational
// lookup from the fetch PC, trained by the resolved branch from EX.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_BITS     = 12,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_BITS = PC_BITS - IDX_BITS;

    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q    [BTB_ENTRIES];
    logic [TAG_BITS-1:0]    tag_d    [BTB_ENTRIES];
    logic [PC_BITS-1:0]     target_q [BTB_ENTRIES];
    logic [PC_BITS-1:0]     target_d [BTB_ENTRIES];
    ctr_e                   ctr_q    [BTB_ENTRIES];
    ctr_e                   ctr_d    [BTB_ENTRIES];

    logic [IDX_BITS-1:0] f_idx, ex_idx;
    logic [TAG_BITS-1:0] f_tag, ex_tag;
    logic [PC_BITS-1:0]  ex_target;
    logic                f_hit, f_taken, ex_hit;
    logic [STAT_W-1:0]   branch_cnt, mispred_cnt;

    assign f_idx     = bp.F_pc[IDX_BITS-1:0];
    assign f_tag     = bp.F_pc[PC_BITS-1:IDX_BITS];
    assign ex_idx    = bp.EX_pc[IDX_BITS-1:0];
    assign ex_tag    = bp.EX_pc[PC_BITS-1:IDX_BITS];
    assign ex_target = bp.EX_alu_out[PC_BITS-1:0];

    generate
        if (XLEN > PC_BITS) begin : g_alu_hi
            logic unused_alu_hi;
            assign unused_alu_hi = ^bp.EX_alu_out[XLEN-1:PC_BITS];
        end
    endgenerate

    // Lookup reads registered state only: no bypass from a same-cycle update.
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit && ctr_q[f_idx][1];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    assign bp.F_BP_taken     = f_taken;
    assign bp.F_BP_target_pc = f_taken ? target_q[f_idx] : bp.F_pc + PC_BITS'(1);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.EX_brn) begin
            if (ex_hit) begin
                ctr_d[ex_idx] = ctr_next(ctr_q[ex_idx], bp.EX_true_taken);
                if (bp.EX_true_taken) target_d[ex_idx] = ex_target;
            end else if (bp.EX_true_taken) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                ctr_d[ex_idx]    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    bp_stat_ctr u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bp.EX_brn),
        .count (branch_cnt)
    );

    bp_stat_ctr u_mispred_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bp.EX_brn && bp.EX_taken),
        .count (mispred_cnt)
    );

    assign bp.BP_branch_cnt  = branch_cnt;
    assign bp.BP_mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed stimulus pushes expected
// predictions/statistics, a negedge monitor pops and compares them.
module tb_branch_predictor;

    logic clk;
    logic rst;

    branch_predictor_if #(.XLEN(32), .PC_BITS(12)) bp_if ();

    branch_predictor #(.XLEN(32), .PC_BITS(12), .BTB_ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_stat;
        logic        taken;
        logic [11:0] target;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   compared   = 0;
    int   mismatched = 0;

    // Monitor: everything queued during a cycle is checked at its negedge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            compared++;
            if (cur.is_stat) begin
                if (bp_if.BP_branch_cnt !== cur.bcnt || bp_if.BP_mispred_cnt !== cur.mcnt) begin
                    mismatched++;
                    $display("FAIL %s: got branch=%08h mispred=%08h, required branch=%08h mispred=%08h",
                             cur.name, bp_if.BP_branch_cnt, bp_if.BP_mispred_cnt, cur.bcnt, cur.mcnt);
                end
            end else begin
                if (bp_if.F_BP_taken !== cur.taken || bp_if.F_BP_target_pc !== cur.target) begin
                    mismatched++;
                    $display("FAIL %s: F_pc=%03h got taken=%0b target=%03h, required taken=%0b target=%03h",
                             cur.name, bp_if.F_pc, bp_if.F_BP_taken, bp_if.F_BP_target_pc,
                             cur.taken, cur.target);
                end
            end
        end
    end

    task automatic drive(input logic [11:0] fpc, input logic brn, input logic [11:0] epc,
                         input logic tt, input logic [11:0] alu, input logic etk);
        bp_if.F_pc          = fpc;
        bp_if.EX_brn        = brn;
        bp_if.EX_pc         = epc;
        bp_if.EX_true_taken = tt;
        bp_if.EX_alu_out    = 32'(alu);
        bp_if.EX_taken      = etk;
    endtask

    task automatic exp_pred(input string n, input logic t, input logic [11:0] tg);
        exp_t e;
        e.name = n; e.is_stat = 1'b0; e.taken = t; e.target = tg;
        e.bcnt = '0; e.mcnt = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_stat(input string n, input logic [31:0] b, input logic [31:0] m);
        exp_t e;
        e.name = n; e.is_stat = 1'b1; e.taken = 1'b0; e.target = '0;
        e.bcnt = b; e.mcnt = m;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset for two edges while a taken branch is presented
        rst = 1'b1;
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h140, 1'b1);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            drive(12'(i), 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
            exp_pred("reset_sweep", 1'b0, 12'(i + 1));
            if (i == 0) exp_stat("reset_stats", 32'd0, 32'd0);
            step();
        end

        // Allocate 0x025 -> 0x140, then hit / same-index tag miss
        drive(12'h000, 1'b1, 12'h025, 1'b1, 12'h140, 1'b1);
        step();
        drive(12'h025, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("alloc_hit", 1'b1, 12'h140);
        step();
        drive(12'h035, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("alloc_tag_miss", 1'b0, 12'h036);
        step();

        // Hysteresis on 0x025 (ctr 10)
        drive(12'h025, 1'b1, 12'h025, 1'b0, 12'h026, 1'b1);
        exp_pred("hyst_nt1_pre", 1'b1, 12'h140);
        step();                                                    // ctr 01
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h140, 1'b1);
        exp_pred("hyst_after_nt", 1'b0, 12'h026);
        step();                                                    // ctr 10
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h140, 1'b0);
        exp_pred("hyst_t2", 1'b1, 12'h140);
        step();                                                    // ctr 11
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h140, 1'b0);
        exp_pred("hyst_t3", 1'b1, 12'h140);
        step();                                                    // ctr 11
        drive(12'h025, 1'b1, 12'h025, 1'b0, 12'h026, 1'b1);
        exp_pred("hyst_st_nt", 1'b1, 12'h140);
        step();                                                    // ctr 10
        drive(12'h025, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("hyst_stays_taken", 1'b1, 12'h140);
        step();
        drive(12'h025, 1'b1, 12'h025, 1'b0, 12'h026, 1'b1);
        exp_pred("hyst_wt_nt", 1'b1, 12'h140);
        step();                                                    // ctr 01
        drive(12'h025, 1'b1, 12'h025, 1'b0, 12'h026, 1'b0);
        exp_pred("hyst_wnt", 1'b0, 12'h026);
        step();                                                    // ctr 00
        drive(12'h025, 1'b1, 12'h025, 1'b0, 12'h026, 1'b0);
        exp_pred("hyst_snt", 1'b0, 12'h026);
        step();                                                    // ctr 00 (saturated)
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h155, 1'b1);
        exp_pred("hyst_snt_sat", 1'b0, 12'h026);
        step();                                                    // ctr 01, tgt 155
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h177, 1'b1);
        exp_pred("hyst_low_sat_nt", 1'b0, 12'h026);
        step();                                                    // ctr 10, tgt 177
        drive(12'h025, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("hit_target_update", 1'b1, 12'h177);
        step();

        // Not-taken miss must not allocate
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b0);
        step();
        drive(12'h050, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("nt_miss_no_alloc", 1'b0, 12'h051);
        step();

        // Conflict on index 3 with same-cycle lookup
        drive(12'h000, 1'b1, 12'h003, 1'b1, 12'h100, 1'b1);
        step();
        drive(12'h003, 1'b1, 12'h013, 1'b1, 12'h200, 1'b1);
        exp_pred("same_cycle_old", 1'b1, 12'h100);
        step();
        drive(12'h003, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("evicted_miss", 1'b0, 12'h004);
        step();
        drive(12'h013, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("conflict_new", 1'b1, 12'h200);
        step();

        // Reset mid-training drops learned state and the same-edge update
        rst = 1'b1;
        drive(12'h025, 1'b1, 12'h025, 1'b1, 12'h300, 1'b1);
        step();
        rst = 1'b0;
        drive(12'h025, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("midreset_025", 1'b0, 12'h026);
        exp_stat("midreset_stats", 32'd0, 32'd0);
        step();
        drive(12'h013, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_pred("midreset_013", 1'b0, 12'h014);
        step();

        // Statistics: 5 branches, 2 mispredicts, 3 non-branch cycles with EX_taken
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b1); step();
        drive(12'h000, 1'b0, 12'h050, 1'b0, 12'h051, 1'b1); step();
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b0); step();
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b1); step();
        drive(12'h000, 1'b0, 12'h050, 1'b0, 12'h051, 1'b1); step();
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b0); step();
        drive(12'h000, 1'b0, 12'h050, 1'b0, 12'h051, 1'b1); step();
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b0); step();
        drive(12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_stat("stats_count", 32'd5, 32'd2);
        step();

        // Saturation at all-ones
        force dut.u_branch_cnt.count_q  = 32'hFFFF_FFFF;
        force dut.u_mispred_cnt.count_q = 32'hFFFF_FFFF;
        step();
        release dut.u_branch_cnt.count_q;
        release dut.u_mispred_cnt.count_q;
        drive(12'h000, 1'b1, 12'h050, 1'b0, 12'h051, 1'b1);
        exp_stat("stats_preload", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        drive(12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
        exp_stat("stats_saturate", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
